// File: rtl/mau_pkg.sv
// Shared types and lane-select helpers for the data-memory access unit.
// Big-endian lanes: byte offset 0 is bits [31:24], halfword offset 0 is bits [31:16].
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WRITE,
    RESP
  } state_e;

  // The encoding 2'b11 is folded onto SZ_WORD so that later logic sees only three sizes.
  function automatic size_e normSize(input logic [1:0] raw);
    return (raw == 2'b11) ? SZ_WORD : size_e'(raw);
  endfunction

  // Right-shift that brings the selected lane down to bit 0.
  function automatic logic [4:0] laneShift(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return {~off, 3'b000};
      SZ_HALF: return {~off[1], 4'b0000};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] laneMask(input size_e sz);
    case (sz)
      SZ_BYTE: return 32'h0000_00FF;
      SZ_HALF: return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic isMisaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Combinational lane handling: extract plus sign/zero extension for loads,
// and lane insertion into a read word for sub-word read-modify-write stores.
module mau_lane_merge
  import mau_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        signExt,
  input  logic [31:0] readWord,
  input  logic [31:0] storeData,
  output logic [31:0] loadResult,
  output logic [31:0] mergedWord
);

  logic [31:0] shifted;
  logic [31:0] masked;
  logic        signBit;

  always_comb begin
    shifted    = readWord >> laneShift(size, offset);
    masked     = shifted & laneMask(size);
    signBit    = (size == SZ_BYTE) ? shifted[7] : shifted[15];
    loadResult = masked;
    if (signExt && signBit && (size != SZ_WORD)) begin
      loadResult = masked | ~laneMask(size);
    end
  end

  // Each byte lane decides independently whether it takes store data or keeps the read byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      localparam int         HI   = 31 - 8 * gi;
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] newByte;
      logic [7:0] outByte;

      always_comb begin
        case (size)
          SZ_BYTE: begin
            hit     = (offset == LANE);
            newByte = storeData[7:0];
          end
          SZ_HALF: begin
            hit     = (offset[1] == LANE[1]);
            newByte = LANE[0] ? storeData[7:0] : storeData[15:8];
          end
          default: begin
            hit     = 1'b1;
            newByte = storeData[HI -: 8];
          end
        endcase
        outByte = hit ? newByte : readWord[HI -: 8];
      end
    end
  endgenerate

  assign mergedWord = {gLane[0].outByte, gLane[1].outByte, gLane[2].outByte, gLane[3].outByte};

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory: sub-word loads, read-modify-write sub-word stores.
// Optional macro MAU_ALIGN_CHECK_EN: misaligned accesses complete immediately with AlignErr.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic          ReqWrite,
  input  logic [1:0]    ReqSize,
  input  logic          ReqSigned,
  input  logic [AW-1:0] ReqAdress,
  input  logic [31:0]   ReqData,
  output logic          RespValid,
  output logic [31:0]   RespData,
  output logic          AlignErr,
  output logic [AW-1:0] MemAdress,
  output logic [31:0]   MemWriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [31:0]   MemReadData
);

  localparam logic [1:0] LAST_CNT = 2'(READ_LAT);

  state_e        stateReg, stateNext;
  logic [1:0]    cntReg;
  logic          writeReg, signedReg, errReg;
  size_e         sizeReg;
  logic [AW-1:0] addrReg;
  logic [31:0]   dataReg, readWordReg;

  size_e       reqSize;
  logic        reqErr;
  logic        accept;
  logic        rdLast;
  logic [31:0] loadResult, mergedWord;

  assign reqSize = normSize(ReqSize);
`ifdef MAU_ALIGN_CHECK_EN
  assign reqErr = isMisaligned(reqSize, ReqAdress[1:0]);
`else
  assign reqErr = 1'b0;
`endif
  assign accept = (stateReg == IDLE) && ReqValid;
  assign rdLast = (cntReg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= 2'd0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= (stateReg == RD_WAIT) ? cntReg + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      writeReg    <= 1'b0;
      signedReg   <= 1'b0;
      errReg      <= 1'b0;
      sizeReg     <= SZ_BYTE;
      addrReg     <= '0;
      dataReg     <= 32'd0;
      readWordReg <= 32'd0;
    end else begin
      if (accept) begin
        writeReg  <= ReqWrite;
        signedReg <= ReqSigned;
        errReg    <= reqErr;
        sizeReg   <= reqSize;
        addrReg   <= ReqAdress;
        dataReg   <= ReqData;
      end
      if ((stateReg == RD_WAIT) && rdLast) begin
        readWordReg <= MemReadData;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (ReqValid) begin
          if (reqErr)                                 stateNext = RESP;
          else if (ReqWrite && (reqSize == SZ_WORD))  stateNext = WRITE;
          else                                        stateNext = RD_WAIT;
        end
      end
      RD_WAIT: if (rdLast) stateNext = writeReg ? WRITE : RESP;
      WRITE:   stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  mau_lane_merge uLaneMerge (
    .size      (sizeReg),
    .offset    (addrReg[1:0]),
    .signExt   (signedReg),
    .readWord  (readWordReg),
    .storeData (dataReg),
    .loadResult(loadResult),
    .mergedWord(mergedWord)
  );

  // Strobes are gated by reset so an access cut short never completes a write.
  always_comb begin
    ReqReady     = (stateReg == IDLE);
    RespValid    = (stateReg == RESP);
    AlignErr     = (stateReg == RESP) && errReg;
    RespData     = ((stateReg == RESP) && !writeReg && !errReg) ? loadResult : 32'd0;
    MemAdress    = {addrReg[AW-1:2], 2'b00};
    MemRead      = (stateReg == RD_WAIT) && !reset;
    MemWrite     = (stateReg == WRITE) && !reset;
    MemWriteData = 32'd0;
    if (stateReg == WRITE) begin
      MemWriteData = (sizeReg == SZ_WORD) ? dataReg : mergedWord;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural DataMemory (READ_LAT=1) plus a spec-level reference model.
// Honours MAU_ALIGN_CHECK_EN when the bench and design are built with it.
module tb_mem_access_unit;

  localparam int READ_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAdress, ReqData;
  logic        RespValid, AlignErr;
  logic [31:0] RespData;
  logic [31:0] MemAdress, MemWriteData, MemReadData;
  logic        MemWrite, MemRead;

  logic [31:0] mem [64];
  logic [31:0] refMem [64];
  logic [31:0] rdData;
  logic        preloadEn = 1'b0;
  logic [5:0]  preloadIdx = 6'd0;
  logic [31:0] preloadVal = 32'd0;

  int nCmp = 0;
  int nErr = 0;
  int txn  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.READ_LAT(READ_LAT), .AW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqWrite    (ReqWrite),
    .ReqSize     (ReqSize),
    .ReqSigned   (ReqSigned),
    .ReqAdress   (ReqAdress),
    .ReqData     (ReqData),
    .RespValid   (RespValid),
    .RespData    (RespData),
    .AlignErr    (AlignErr),
    .MemAdress   (MemAdress),
    .MemWriteData(MemWriteData),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .MemReadData (MemReadData)
  );

  // DataMemory: one-cycle registered read, write on the edge after MemWrite.
  always @(posedge clk) begin
    if (preloadEn) mem[preloadIdx] <= preloadVal;
    else if (MemWrite) mem[MemAdress[7:2]] <= MemWriteData;
    if (MemRead) rdData <= mem[MemAdress[7:2]];
  end
  assign MemReadData = rdData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    preloadEn  = 1'b1;
    preloadIdx = addr[7:2];
    preloadVal = val;
    refMem[addr[7:2]] = val;
    @(posedge clk);
    #1 preloadEn = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where RespValid is seen.
  task automatic doReq(input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] d, input bit hold);
    int          nsz, sh, expLat, expRd, expWr, lat, rdCnt, wrCnt, k;
    bit          err, conflict, addrBad, readyBad, gotResp;
    logic [5:0]  idx;
    logic [31:0] word, expData, mask;
    nsz = (sz == 2'd3) ? 2 : int'(sz);
    err = 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
    err = (nsz == 1 && addr[0]) || (nsz == 2 && addr[1:0] != 2'b00);
`endif
    idx = addr[7:2];
    word = refMem[idx];
    expData = 32'd0; expRd = 0; expWr = 0;
    sh   = (nsz == 0) ? 8 * (3 - int'(addr[1:0])) : (nsz == 1) ? 16 * (1 - int'(addr[1])) : 0;
    mask = (nsz == 0) ? 32'hFF : (nsz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (err) begin
      expLat = 1;
    end else if (!w) begin
      expLat = READ_LAT + 2; expRd = READ_LAT + 1;
      expData = (word >> sh) & mask;
      if (sg && nsz == 0 && expData[7])  expData = expData | 32'hFFFF_FF00;
      if (sg && nsz == 1 && expData[15]) expData = expData | 32'hFFFF_0000;
    end else if (nsz == 2) begin
      expLat = 2; expWr = 1;
      refMem[idx] = d;
    end else begin
      expLat = READ_LAT + 3; expRd = READ_LAT + 1; expWr = 1;
      refMem[idx] = (word & ~(mask << sh)) | ((d & mask) << sh);
    end

    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAdress = addr; ReqData = d;
    k = 0;
    while (!ReqReady && k < 20) begin @(negedge clk); k++; end
    check("ready_before_accept", {31'd0, ReqReady}, 32'd1);
    @(posedge clk);
    #1;
    ReqWrite = 1'($urandom); ReqSize = 2'($urandom); ReqSigned = 1'($urandom);
    ReqAdress = $urandom; ReqData = $urandom;
    if (!hold) ReqValid = 1'b0;

    conflict = 0; addrBad = 0; readyBad = 0; gotResp = 0; rdCnt = 0; wrCnt = 0; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (MemRead && MemWrite) conflict = 1;
      if (MemRead) rdCnt++;
      if (MemWrite) wrCnt++;
      if ((MemRead || MemWrite) && MemAdress !== {addr[31:2], 2'b00}) addrBad = 1;
      if (ReqReady) readyBad = 1;
      if (RespValid) begin gotResp = 1; lat = c; break; end
    end
    txn++;
    $display("txn %0d: %s size=%0d signed=%0b addr=%h data=%h -> resp=%h alignErr=%0b latency=%0d",
             txn, w ? "store" : "load", sz, sg, addr, d, RespData, AlignErr, lat);
    check("resp_seen", {31'd0, gotResp}, 32'd1);
    check("latency", 32'(lat), 32'(expLat));
    check("resp_data", RespData, expData);
    check("align_err", {31'd0, AlignErr}, {31'd0, err});
    check("read_cycles", 32'(rdCnt), 32'(expRd));
    check("write_pulses", 32'(wrCnt), 32'(expWr));
    check("strobe_exclusive", {31'd0, conflict}, 32'd0);
    check("mem_addr_stable", {31'd0, addrBad}, 32'd0);
    check("ready_low_busy", {31'd0, readyBad}, 32'd0);
    check("mem_contents", mem[idx], refMem[idx]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int k;
    for (int i = 0; i < 64; i++) refMem[i] = 32'd0;
    reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0;
    ReqSigned = 1'b0; ReqAdress = 32'd0; ReqData = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ReqReady", {31'd0, ReqReady}, 32'd1);
    check("rst_RespValid", {31'd0, RespValid}, 32'd0);
    check("rst_RespData", RespData, 32'd0);
    check("rst_AlignErr", {31'd0, AlignErr}, 32'd0);
    check("rst_MemAdress", MemAdress, 32'd0);
    check("rst_MemWriteData", MemWriteData, 32'd0);
    check("rst_MemWrite", {31'd0, MemWrite}, 32'd0);
    check("rst_MemRead", {31'd0, MemRead}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) preload(32'(i * 4), 32'd0);

    // Word store then word load.
    doReq(1, 2'd2, 0, 32'h10, 32'd40, 0);
    doReq(0, 2'd2, 0, 32'h10, 32'd0, 0);
    check("s1_lw_value", RespData, 32'd40);

    // Sub-word loads with extension.
    preload(32'h20, 32'h80FF_7F01);
    doReq(0, 2'd0, 1, 32'h21, 32'd0, 0);
    check("s2_lb", RespData, 32'hFFFF_FFFF);
    doReq(0, 2'd0, 0, 32'h20, 32'd0, 0);
    check("s2_lbu", RespData, 32'h0000_0080);
    doReq(0, 2'd1, 1, 32'h22, 32'd0, 0);
    check("s2_lh", RespData, 32'h0000_7F01);

    // Read-modify-write stores.
    preload(32'h30, 32'h1122_3344);
    doReq(1, 2'd0, 0, 32'h32, 32'h0000_00AA, 0);
    check("s3_sb", mem[12], 32'h1122_AA44);
    doReq(1, 2'd1, 0, 32'h30, 32'h0000_BEEF, 0);
    check("s3_sh", mem[12], 32'hBEEF_AA44);

    // Misaligned word load.
    doReq(0, 2'd2, 0, 32'h31, 32'd0, 0);
`ifdef MAU_ALIGN_CHECK_EN
    check("s4_misaligned_data", RespData, 32'd0);
`else
    check("s4_forced_align", RespData, 32'hBEEF_AA44);
`endif

    // Reset while the write of a sub-word store is pending.
    preload(32'h40, 32'hCAFE_F00D);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqSigned = 1'b0;
    ReqAdress = 32'h41; ReqData = 32'h55;
    k = 0;
    while (!ReqReady && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    #1 ReqValid = 1'b0;
    k = 0;
    while (!MemWrite && k < 20) begin @(negedge clk); k++; end
    check("s5_reached_write", {31'd0, MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check("s5_write_gated", {31'd0, MemWrite}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("s5_ready_after", {31'd0, ReqReady}, 32'd1);
    check("s5_no_resp", {31'd0, RespValid}, 32'd0);
    check("s5_mem_unchanged", mem[16], 32'hCAFE_F00D);
    txn++;
    $display("txn %0d: sub-word store abandoned by reset, mem[0x40]=%h", txn, mem[16]);

    // Continuous ReqValid with alternating word store / word load.
    for (int i = 0; i < 8; i++) begin
      a = {24'd0, 8'($urandom)} & 32'hFC;
      d = $urandom;
      doReq(1, 2'd2, 0, a, d, 1);
      doReq(0, 2'd2, 0, a, 32'd0, 1);
      check("s6_roundtrip", RespData, d);
    end
    ReqValid = 1'b0;

    // Randomised mix.
    for (int i = 0; i < 40; i++) begin
      doReq(1'($urandom), 2'($urandom), 1'($urandom), {24'd0, 8'($urandom)}, $urandom, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
